// File: rtl/jtsdram_progn.sv
// jtsdram_progn - SDRAM programmer / verifier for the SDRAM test core.
//
// Sweeps every word (HALF=0) or every byte half (HALF=1) of banks
// 0..BANKS-1 over an AW-bit word address space. In write mode each
// location is filled from its bank's pattern word. In verify mode each
// location is read back, and the enabled bytes are compared against the
// pattern. Mismatches are counted in a saturating counter, and the first
// mismatch location is recorded.
//
// During active video, traffic is only issued on one frame out of
// RFSH_DIV. This leaves the controller free for refresh.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, mode       start pulse (restarts a sweep), 0=write 1=verify
//   LVBL              vertical blank, active-low (1 = active video)
//   ba_data           pattern words, bank n at [16n+15:16n]
//   prog_*            SDRAM controller programming port
//   done, busy        sweep status
//   err_cnt, err_addr mismatch count, {ba,addr,half} of first mismatch
module jtsdram_progn #(
    parameter int AW       = 22,
    parameter int BANKS    = 4,
    parameter int HALF     = 1,
    parameter int RFSH_DIV = 2,
    parameter int ERRW     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic            LVBL,
    input  logic [63:0]     ba_data,
    input  logic [15:0]     prog_dout,
    output logic            done,
    output logic            busy,
    output logic [AW-1:0]   prog_addr,
    output logic [15:0]     prog_data,
    output logic [1:0]      prog_mask,
    output logic [1:0]      prog_ba,
    output logic            prog_we,
    output logic            prog_rd,
    input  logic            prog_ack,
    input  logic            prog_rdy,
    output logic [ERRW-1:0] err_cnt,
    output logic [AW+2:0]   err_addr
);

    localparam int CW = 2 + AW + HALF;
    localparam logic [CW-1:0] LAST = {2'(BANKS - 1), {(AW + HALF){1'b1}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            half_q, half_d;
    logic            lvbl_q;
    logic [3:0]      frame_q, frame_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic [1:0]      ba_q, ba_d;
    logic            we_q, we_d;
    logic            rd_q, rd_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [AW+2:0]   erra_q, erra_d;

    // Location currently pointed at by the sweep counter
    logic [1:0]      cnt_ba;
    logic [AW-1:0]   cnt_addr;
    logic            cnt_half;
    logic [1:0]      mask_act;
    logic            mismatch;
    logic            slot_open;

    assign cnt_ba   = cnt_q[CW-1 -: 2];
    assign cnt_addr = cnt_q[HALF +: AW];
    assign cnt_half = (HALF != 0) ? cnt_q[0] : 1'b0;

    // Mask of the access in flight (1 = byte disabled). half=1 selects the low byte.
    assign mask_act = (HALF != 0) ? {half_q, ~half_q} : 2'b00;

    // Only the bytes the access actually touched take part in the comparison
    assign mismatch = (!mask_act[1] && (prog_dout[15:8] != data_q[15:8])) ||
                      (!mask_act[0] && (prog_dout[7:0]  != data_q[7:0]));

    assign slot_open = !LVBL || (frame_q == 4'd0);

    // Frame counter runs in every state so throttling phase is never lost
    always_comb begin
        frame_d = frame_q;
        if (LVBL && !lvbl_q)
            frame_d = (frame_q == 4'(RFSH_DIV - 1)) ? 4'd0 : frame_q + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        half_d  = half_q;
        done_d  = done_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ba_d    = ba_q;
        we_d    = we_q;
        rd_d    = rd_q;
        err_d   = err_q;
        erra_d  = erra_q;
        if (start) begin
            // start wins over any handshake seen in the same cycle
            state_d = ISSUE;
            cnt_d   = '0;
            mode_d  = mode;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            we_d    = 1'b0;
            rd_d    = 1'b0;
            err_d   = '0;
            erra_d  = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ISSUE: begin
                    if (slot_open) begin
                        ba_d    = cnt_ba;
                        addr_d  = cnt_addr;
                        half_d  = cnt_half;
                        data_d  = ba_data[16*cnt_ba +: 16];
                        we_d    = ~mode_q;
                        rd_d    = mode_q;
                        busy_d  = 1'b1;
                        state_d = WAIT;
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                WAIT: begin
                    if (prog_ack) begin
                        we_d = 1'b0;
                        rd_d = 1'b0;
                    end
                    if (prog_rdy) begin
                        we_d = 1'b0;
                        rd_d = 1'b0;
                        if (mode_q && mismatch) begin
                            if (err_q != {ERRW{1'b1}}) err_d = err_q + 1'b1;
                            if (err_q == '0) erra_d = {ba_q, addr_q, half_q};
                        end
                        if (cnt_q == LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = ISSUE;
                        end
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    we_d   = 1'b0;
                    rd_d   = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            half_q  <= 1'b0;
            lvbl_q  <= 1'b0;
            frame_q <= 4'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ba_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= '0;
            erra_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            half_q  <= half_d;
            lvbl_q  <= LVBL;
            frame_q <= frame_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ba_q    <= ba_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            erra_q  <= erra_d;
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign prog_addr = addr_q;
    assign prog_data = data_q;
    assign prog_ba   = ba_q;
    assign prog_we   = we_q;
    assign prog_rd   = rd_q;
    assign prog_mask = done_q ? 2'b11 : mask_act;
    assign err_cnt   = err_q;
    assign err_addr  = erra_q;

endmodule

// File: tb/tb_jtsdram_progn.sv
module tb_jtsdram_progn;
    localparam int AW       = 4;
    localparam int BANKS    = 2;
    localparam int HALF     = 1;
    localparam int RFSH_DIV = 2;
    localparam int ERRW     = 4;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            mode;
    logic            LVBL;
    logic [63:0]     ba_data;
    logic [15:0]     prog_dout;
    logic            done;
    logic            busy;
    logic [AW-1:0]   prog_addr;
    logic [15:0]     prog_data;
    logic [1:0]      prog_mask;
    logic [1:0]      prog_ba;
    logic            prog_we;
    logic            prog_rd;
    logic            prog_ack;
    logic            prog_rdy;
    logic [ERRW-1:0] err_cnt;
    logic [AW+2:0]   err_addr;

    int n_assert = 0;
    int n_fail   = 0;

    jtsdram_progn #(
        .AW(AW), .BANKS(BANKS), .HALF(HALF), .RFSH_DIV(RFSH_DIV), .ERRW(ERRW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .LVBL(LVBL),
        .ba_data(ba_data), .prog_dout(prog_dout), .done(done), .busy(busy),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_ba(prog_ba), .prog_we(prog_we), .prog_rd(prog_rd),
        .prog_ack(prog_ack), .prog_rdy(prog_rdy), .err_cnt(err_cnt),
        .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serves n accesses of a sweep that has just been started (or just had an
    // access completed). Each request must show up exactly one cycle later.
    // bad: 0 clean, 1 low byte wrong at index 43, 2 high byte wrong at 43,
    // 3 every read wrong.
    task automatic sweep(input logic v, input int n, input int bad, input int lat);
        logic [5:0]  ix;
        logic [1:0]  eba;
        logic [1:0]  emask;
        logic [3:0]  eaddr;
        logic        eh;
        logic [15:0] edata;
        logic [15:0] dout;
        for (int i = 0; i < n; i++) begin
            tick;
            ix    = 6'(i);
            eba   = {1'b0, ix[5]};
            eaddr = ix[4:1];
            eh    = ix[0];
            emask = eh ? 2'b10 : 2'b01;
            edata = ix[5] ? 16'h3CC3 : 16'hA55A;
            chk($sformatf("req%0d", i),
                64'({prog_we, prog_rd, prog_ba, prog_addr, prog_mask, prog_data, busy}),
                64'({~v, v, eba, eaddr, emask, edata, 1'b1}));
            repeat (lat) tick;
            dout = edata;
            if (bad == 3) dout = ~edata;
            else if (bad == 1 && i == 43) dout = edata ^ 16'h0001;
            else if (bad == 2 && i == 43) dout = edata ^ 16'h0100;
            prog_dout = dout;
            prog_ack  = 1'b1;
            prog_rdy  = 1'b1;
            tick;
            prog_ack  = 1'b0;
            prog_rdy  = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode  = m;
        tick;
        start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        LVBL      = 1'b0;
        ba_data   = {16'hDEAD, 16'hBEEF, 16'h3CC3, 16'hA55A};
        prog_dout = 16'h0000;
        prog_ack  = 1'b0;
        prog_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick;
        chk("reset_idle",
            64'({done, busy, prog_addr, prog_data, prog_ba, prog_we, prog_rd, err_cnt, err_addr, prog_mask}),
            64'({1'b0, 1'b0, 4'd0, 16'd0, 2'd0, 1'b0, 1'b0, 4'd0, 7'd0, 2'b01}));

        // Full write sweep, ack+rdy three cycles after each request
        pulse_start(1'b0);
        sweep(1'b0, 64, 0, 3);
        chk("wr_done", 64'({done, prog_mask, busy, prog_we, prog_rd, err_cnt}),
            64'({1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0}));
        repeat (3) tick;
        chk("wr_done_hold", 64'({done, prog_mask, prog_we}), 64'({1'b1, 2'b11, 1'b0}));

        // Verify: enabled (low) byte wrong at ba=1 addr=5 half=1
        pulse_start(1'b1);
        sweep(1'b1, 64, 1, 1);
        chk("vf_err_cnt", 64'(err_cnt), 64'd1);
        chk("vf_err_addr", 64'(err_addr), 64'({2'b01, 4'd5, 1'b1}));
        chk("vf_done", 64'({done, prog_mask}), 64'({1'b1, 2'b11}));

        // Verify: disabled (high) byte wrong at the same spot, simultaneous ack+rdy
        pulse_start(1'b1);
        sweep(1'b1, 64, 2, 0);
        chk("vf_masked_cnt", 64'(err_cnt), 64'd0);
        chk("vf_masked_addr", 64'(err_addr), 64'd0);

        // Every read wrong: counter saturates at 15 within 20 accesses
        pulse_start(1'b1);
        sweep(1'b1, 20, 3, 0);
        chk("sat_cnt", 64'(err_cnt), 64'd15);
        tick;
        chk("rs_req20", 64'({prog_we, prog_rd, prog_ba, prog_addr, busy}),
            64'({1'b0, 1'b1, 2'd0, 4'd10, 1'b1}));

        // Restart in the middle of WAIT as a write sweep
        pulse_start(1'b0);
        chk("rs_drop", 64'({prog_we, prog_rd, err_cnt, err_addr, done}),
            64'({1'b0, 1'b0, 4'd0, 7'd0, 1'b0}));
        sweep(1'b0, 25, 0, 2);
        tick;
        chk("rs_req25", 64'({prog_we, prog_ba, prog_addr, prog_mask}),
            64'({1'b1, 2'd0, 4'd12, 2'b10}));

        // Asynchronous reset mid-sweep, observed before the next clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst",
            64'({done, busy, prog_addr, prog_data, prog_ba, prog_we, prog_rd, err_cnt, err_addr, prog_mask}),
            64'({1'b0, 1'b0, 4'd0, 16'd0, 2'd0, 1'b0, 1'b0, 4'd0, 7'd0, 2'b01}));
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        chk("rst_no_resume", 64'({prog_we, prog_rd, busy, done}), 64'd0);

        // Throttling: frame 1 active video blocks requests
        LVBL = 1'b1;
        repeat (3) tick;
        pulse_start(1'b0);
        repeat (8) tick;
        chk("thr_closed", 64'({prog_we, busy}), 64'd0);
        LVBL = 1'b0;
        tick;
        chk("thr_blank", 64'({prog_we, prog_addr, prog_mask}), 64'({1'b1, 4'd0, 2'b01}));
        prog_ack = 1'b1;
        tick;
        prog_ack = 1'b0;
        chk("thr_ack", 64'({prog_we, busy}), 64'({1'b0, 1'b1}));
        // Two rising edges while WAIT: frame 1 -> 0 -> 1
        LVBL = 1'b1;
        tick;
        LVBL = 1'b0;
        tick;
        LVBL = 1'b1;
        tick;
        prog_rdy = 1'b1;
        tick;
        prog_rdy = 1'b0;
        repeat (5) tick;
        chk("thr_hold", 64'({prog_we, busy, done}), 64'd0);
        LVBL = 1'b0;
        tick;
        chk("thr_resume", 64'({prog_we, prog_addr, prog_mask}), 64'({1'b1, 4'd0, 2'b10}));
        prog_ack = 1'b1;
        prog_rdy = 1'b1;
        tick;
        prog_ack = 1'b0;
        prog_rdy = 1'b0;
        LVBL = 1'b1;
        tick;
        chk("thr_edge", 64'(prog_we), 64'd0);
        tick;
        chk("thr_even", 64'({prog_we, prog_addr, prog_mask}), 64'({1'b1, 4'd1, 2'b01}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jtsdram_progn.md
Name: jtsdram_progn

Overview:
- Parametrised SDRAM programmer/verifier for the SDRAM test core.
- Sweeps every word (or byte half) of a configurable number of banks and address width.
- Write mode fills SDRAM from per-bank pattern generators; verify mode reads the same locations back and counts mismatches.
- Sits between the pattern generators and the SDRAM controller programming port; throttles traffic against video blanking to leave refresh slots.

Parameters:
- AW, 22: SDRAM word address width of prog_addr.
- BANKS, 4: number of banks swept, 1..4. Banks 0..BANKS-1 are visited in order; prog_ba is always 2 bits.
- HALF, 1: 1 = byte-granular sweep (each word accessed twice, once per byte); 0 = word sweep, prog_mask=00 while active.
- RFSH_DIV, 2: frame divider for active-video throttling. Traffic runs during active video only on frames where frame_cnt==0 (mod RFSH_DIV). RFSH_DIV=1 means no throttling. Range 1..16.
- ERRW, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; (re)starts a sweep
- mode  in  1  0=write, 1=verify; sampled on start
- LVBL  in  1  vertical blank, active-low (1=active video)
- ba_data  in  64  pattern words, bank n at bits [16n+15:16n]
- prog_dout  in  16  SDRAM read data, valid with prog_rdy in verify mode
- done  out  1  sweep finished
- busy  out  1  sweep in progress and currently issuing/waiting
- prog_addr  out  AW  word address
- prog_data  out  16  write data / expected data
- prog_mask  out  2  byte mask, 1=byte disabled
- prog_ba  out  2  bank
- prog_we  out  1  write request
- prog_rd  out  1  read request
- prog_ack  in  1  controller accepted request
- prog_rdy  in  1  access complete
- err_cnt  out  ERRW  mismatches in the last verify sweep, saturating
- err_addr  out  2+AW+1  {ba,addr,half} of the first mismatch; 0 if none

Behaviour:
- Reset values: done=0, busy=0, prog_addr=0, prog_data=0, prog_ba=0, prog_we=0, prog_rd=0, err_cnt=0, err_addr=0, frame_cnt=0, state=IDLE. Reset mid-sweep aborts immediately; there is no resume.
- Linear counter cnt, width 2+AW+HALF. It holds {ba,addr,half} when HALF=1 and {ba,addr} when HALF=0.
- Last count = {BANKS-1, all ones}. The counter never exceeds it, so there is no wrap.
- prog_mask = done ? 11 : (HALF ? {half,~half} : 00). half=1 enables the low byte; half=0 enables the high byte.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: outputs idle. start -> ISSUE with cnt=0, done=0, err_cnt=0, err_addr=0, mode latched.
  - ISSUE: a slot is open when LVBL=0 or frame_cnt==0.
    - Open slot: in one cycle, load {prog_ba,prog_addr,half} from cnt. Load prog_data from ba_data of the bank being issued (the new bank, not the previous one). Assert prog_we (write mode) or prog_rd (verify mode). Set busy=1. Go to WAIT.
    - Closed slot: busy=0, stay in ISSUE.
  - WAIT:
    - prog_ack clears prog_we/prog_rd.
    - prog_rdy ends the access:
      - Verify mode: compare only the enabled bytes of prog_dout with prog_data. On mismatch, err_cnt increments, saturating at all ones, and err_addr is captured only if err_cnt was 0.
      - If cnt==last: go to DONE.
      - Otherwise: cnt+1, go to ISSUE.
    - prog_ack and prog_rdy in the same cycle are both honoured in that cycle.
  - DONE: done=1, busy=0, prog_we=prog_rd=0. Holds until start.
- frame_cnt increments mod RFSH_DIV on each LVBL rising edge, every state. A closed slot never interrupts an access already in WAIT.
- start in any state, including WAIT, restarts from cnt=0 next cycle: prog_we/prog_rd drop, err cleared. start has priority over ack/rdy in the same cycle.
- Request-to-issue latency: one cycle from entering ISSUE with an open slot.

Test Plan:
- Write, AW=4, BANKS=2, HALF=1, ack+rdy 3 cycles after each request, LVBL=0 -> 64 requests, addresses 0..15 per bank, masks alternate 01/10, done=1 after the last rdy, prog_mask=11.
- Verify with prog_dout equal to prog_data except one byte wrong at ba=1, addr=5, half=1 (enabled byte) -> err_cnt=1, err_addr={1,5,1}. A mismatch in the disabled byte -> err_cnt=0.
- RFSH_DIV=2, LVBL toggling -> no new request during active video on odd frames; requests during blanking every frame; an in-flight access completes.
- start pulse mid-WAIT at count 20 -> prog_we low next cycle, sweep restarts at 0, err_cnt=0.
- ERRW=4, all reads mismatching -> err_cnt saturates at 15. Simultaneous ack+rdy -> the next request issues one cycle later.
- rst_n low mid-sweep -> all outputs at reset values asynchronously; done=0.
